// File: rtl/echo_indication_output.sv
// rtl/echo_indication_output.sv - serializes heard/heard2 calls into header-prefixed words on an outbound pipe
module echo_indication_output (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        heard__ENA,
  input  logic [31:0] heard_meth,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  input  logic        heard2__ENA,
  input  logic [15:0] heard2_a,
  input  logic [15:0] heard2_b,
  output logic        heard2__RDY,
  output logic        pipe_enq__ENA,
  output logic [31:0] pipe_enq_v,
  input  logic        pipe_enq__RDY
);

  typedef enum logic [1:0] {IDLE, HDR, W1, W2} state_t;

  localparam logic [15:0] TAG_HEARD  = 16'd1;
  localparam logic [15:0] TAG_HEARD2 = 16'd2;

  state_t      state, state_next;
  logic [15:0] tag;
  logic [31:0] word1, word2;
  logic        last_word, base_rdy, accept_heard, accept_heard2;

  // The last word of a message may hand over to a new call in the same cycle.
  assign last_word     = (state == W2) || (state == W1 && tag == TAG_HEARD2);
  assign base_rdy      = nRST && ((state == IDLE) || (last_word && pipe_enq__RDY));
  assign accept_heard  = heard__ENA && base_rdy;
  assign accept_heard2 = heard2__ENA && base_rdy && !heard__ENA;

  assign heard__RDY    = base_rdy;
  assign heard2__RDY   = base_rdy && !heard__ENA;
  assign pipe_enq__ENA = (state != IDLE);

  always_comb begin
    pipe_enq_v = 32'd0;
    case (state)
      HDR:     pipe_enq_v = (tag == TAG_HEARD) ? {16'd3, TAG_HEARD} : {16'd2, TAG_HEARD2};
      W1:      pipe_enq_v = word1;
      W2:      pipe_enq_v = word2;
      default: pipe_enq_v = 32'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (accept_heard || accept_heard2) begin
      state_next = HDR;
    end else if (state != IDLE && pipe_enq__RDY) begin
      case (state)
        HDR:     state_next = W1;
        W1:      state_next = (tag == TAG_HEARD) ? W2 : IDLE;
        W2:      state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tag   <= 16'd0;
      word1 <= 32'd0;
      word2 <= 32'd0;
    end else if (accept_heard) begin
      tag   <= TAG_HEARD;
      word1 <= heard_meth;
      word2 <= heard_v;
    end else if (accept_heard2) begin
      tag   <= TAG_HEARD2;
      word1 <= {heard2_a, heard2_b};
      word2 <= 32'd0;
    end
  end

endmodule

// File: tb/tb_echo_indication_output.sv
// tb/tb_echo_indication_output.sv - randomized scoreboard bench for echo_indication_output
module tb_echo_indication_output;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        heard__ENA = 1'b0;
  logic [31:0] heard_meth = '0;
  logic [31:0] heard_v = '0;
  logic        heard__RDY;
  logic        heard2__ENA = 1'b0;
  logic [15:0] heard2_a = '0;
  logic [15:0] heard2_b = '0;
  logic        heard2__RDY;
  logic        pipe_enq__ENA;
  logic [31:0] pipe_enq_v;
  logic        pipe_enq__RDY = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accepts = 0;
  int acc_c = 0;
  bit armed = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] log_w[$];
  int          log_c[$];
  logic        mrdy;
  logic [31:0] ew;
  int          n;

  echo_indication_output dut (
    .CLK(CLK), .nRST(nRST),
    .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v), .heard__RDY(heard__RDY),
    .heard2__ENA(heard2__ENA), .heard2_a(heard2_a), .heard2_b(heard2_b), .heard2__RDY(heard2__RDY),
    .pipe_enq__ENA(pipe_enq__ENA), .pipe_enq_v(pipe_enq_v), .pipe_enq__RDY(pipe_enq__RDY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  // Reference: a queue of words still owed to the pipe; the caller may enter when it is
  // empty or about to drain its final word.
  always @(negedge CLK) if (armed) begin
    n    = exp_q.size();
    mrdy = nRST && (n == 0 || (n == 1 && pipe_enq__RDY));
    ew   = (n != 0) ? exp_q[0] : 32'd0;
    checks++;
    if (heard__RDY !== mrdy) begin
      errors++; $display("FAIL heard_rdy cycle %0d got %b want %b", cycle, heard__RDY, mrdy);
    end
    checks++;
    if (heard2__RDY !== (mrdy && !heard__ENA)) begin
      errors++; $display("FAIL heard2_rdy cycle %0d got %b want %b", cycle, heard2__RDY, mrdy && !heard__ENA);
    end
    checks++;
    if (pipe_enq__ENA !== (n != 0)) begin
      errors++; $display("FAIL enq_ena cycle %0d got %b want %b", cycle, pipe_enq__ENA, n != 0);
    end
    checks++;
    if (pipe_enq_v !== ew) begin
      errors++; $display("FAIL enq_v cycle %0d got %h want %h", cycle, pipe_enq_v, ew);
    end
    if (n != 0 && pipe_enq__RDY) begin
      void'(exp_q.pop_front());
      log_w.push_back(pipe_enq_v);
      log_c.push_back(cycle);
    end
    if (!nRST) begin
      exp_q.delete();
    end else if (heard__ENA && mrdy) begin
      exp_q.push_back({16'd3, 16'd1}); exp_q.push_back(heard_meth); exp_q.push_back(heard_v);
      accepts++; acc_c = cycle;
    end else if (heard2__ENA && mrdy && !heard__ENA) begin
      exp_q.push_back({16'd2, 16'd2}); exp_q.push_back({heard2_a, heard2_b});
      accepts++; acc_c = cycle;
    end
  end

  task automatic cyc(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic clear_log();
    log_w.delete(); log_c.delete();
  endtask

  task automatic test_reset();
    nRST = 1'b0; pipe_enq__RDY = 1'b0;
    cyc(2);
    armed = 1'b1;
    @(negedge CLK);
    checks++;
    if (heard__RDY !== 1'b0 || heard2__RDY !== 1'b0 || pipe_enq__ENA !== 1'b0 || pipe_enq_v !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got rdy %b/%b ena %b v %h want 0/0 0 0", heard__RDY, heard2__RDY, pipe_enq__ENA, pipe_enq_v);
    end
    cyc(1);
    nRST = 1'b1; pipe_enq__RDY = 1'b0;
    cyc(1);
    @(negedge CLK);
    checks++;
    if (heard__RDY !== 1'b1 || heard2__RDY !== 1'b1) begin
      errors++; $display("FAIL release_rdy got %b/%b want 1/1", heard__RDY, heard2__RDY);
    end
    cyc(1);
  endtask

  task automatic test_heard();
    pipe_enq__RDY = 1'b1; clear_log();
    heard__ENA = 1'b1; heard_meth = 32'h11223344; heard_v = 32'hAABBCCDD;
    cyc(1);
    heard__ENA = 1'b0;
    cyc(5);
    checks++;
    if (log_w.size() != 3) begin
      errors++; $display("FAIL heard_count got %0d want 3", log_w.size());
    end else begin
      checks++;
      if (log_w[0] !== 32'h00030001 || log_w[1] !== 32'h11223344 || log_w[2] !== 32'hAABBCCDD) begin
        errors++; $display("FAIL heard_words got %h %h %h want 00030001 11223344 aabbccdd", log_w[0], log_w[1], log_w[2]);
      end
      checks++;
      if (log_c[0] != acc_c + 1 || log_c[2] != log_c[0] + 2) begin
        errors++; $display("FAIL heard_timing got hdr %0d last %0d want %0d %0d", log_c[0], log_c[2], acc_c + 1, acc_c + 3);
      end
    end
  endtask

  task automatic test_heard2_backpressure();
    pipe_enq__RDY = 1'b0; clear_log();
    heard2__ENA = 1'b1; heard2_a = 16'h1234; heard2_b = 16'h5678;
    cyc(1);
    heard2__ENA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (pipe_enq__ENA !== 1'b1 || pipe_enq_v !== 32'h00020002 || heard__RDY !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got ena %b v %h rdy %b want 1 00020002 0", i, pipe_enq__ENA, pipe_enq_v, heard__RDY);
      end
      cyc(1);
    end
    pipe_enq__RDY = 1'b1;
    cyc(4);
    checks++;
    if (log_w.size() != 2 || log_w[0] !== 32'h00020002 || log_w[1] !== 32'h12345678) begin
      errors++; $display("FAIL heard2_words got n=%0d want 00020002 12345678", log_w.size());
    end
  endtask

  task automatic test_simultaneous();
    bit got;
    pipe_enq__RDY = 1'b1; clear_log();
    heard__ENA = 1'b1; heard_meth = 32'd1; heard_v = 32'd2;
    heard2__ENA = 1'b1; heard2_a = 16'd3; heard2_b = 16'd4;
    @(negedge CLK);
    checks++;
    if (heard__RDY !== 1'b1 || heard2__RDY !== 1'b0) begin
      errors++; $display("FAIL simul_rdy got %b/%b want 1/0", heard__RDY, heard2__RDY);
    end
    cyc(1);
    heard__ENA = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); got = heard2__RDY;
      cyc(1);
      if (got) break;
    end
    heard2__ENA = 1'b0;
    cyc(5);
    checks++;
    if (log_w.size() != 5) begin
      errors++; $display("FAIL simul_count got %0d want 5", log_w.size());
    end else begin
      checks++;
      if (log_w[0] !== 32'h00030001 || log_w[1] !== 32'd1 || log_w[2] !== 32'd2 ||
          log_w[3] !== 32'h00020002 || log_w[4] !== 32'h00030004) begin
        errors++; $display("FAIL simul_words got %h %h %h %h %h", log_w[0], log_w[1], log_w[2], log_w[3], log_w[4]);
      end
      checks++;
      if (log_c[4] != log_c[0] + 4) begin
        errors++; $display("FAIL simul_gap got span %0d want 4", log_c[4] - log_c[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int calls = 0;
    bit got;
    pipe_enq__RDY = 1'b1; clear_log();
    for (int i = 0; i < 40 && calls < 5; i++) begin
      heard__ENA = 1'b1; heard_meth = 32'h100 + calls; heard_v = ~(32'h100 + calls);
      @(negedge CLK); got = heard__RDY;
      cyc(1);
      if (got) calls++;
    end
    heard__ENA = 1'b0;
    cyc(5);
    checks++;
    if (log_w.size() != 15) begin
      errors++; $display("FAIL b2b_count got %0d want 15", log_w.size());
    end else begin
      checks++;
      if (log_c[14] != log_c[0] + 14) begin
        errors++; $display("FAIL b2b_gap got span %0d want 14", log_c[14] - log_c[0]);
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (log_w[3*k] !== 32'h00030001 || log_w[3*k+1] !== 32'h100 + k || log_w[3*k+2] !== ~(32'h100 + k)) begin
          errors++; $display("FAIL b2b_msg%0d got %h %h %h", k, log_w[3*k], log_w[3*k+1], log_w[3*k+2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pipe_enq__RDY = 1'b1;
    heard__ENA = 1'b1; heard_meth = 32'hDEAD0001; heard_v = 32'hDEAD0002;
    cyc(1);
    heard__ENA = 1'b0;
    cyc(1);
    nRST = 1'b0;
    cyc(1);
    clear_log();
    @(negedge CLK);
    checks++;
    if (pipe_enq__ENA !== 1'b0 || pipe_enq_v !== 32'd0) begin
      errors++; $display("FAIL mid_reset got ena %b v %h want 0 0", pipe_enq__ENA, pipe_enq_v);
    end
    cyc(1);
    nRST = 1'b1;
    heard2__ENA = 1'b1; heard2_a = 16'd0; heard2_b = 16'd0;
    cyc(1);
    heard2__ENA = 1'b0;
    cyc(6);
    checks++;
    if (log_w.size() != 2 || log_w[0] !== 32'h00020002 || log_w[1] !== 32'd0) begin
      errors++; $display("FAIL mid_after got n=%0d want 2 words 00020002 00000000", log_w.size());
    end
  endtask

  task automatic test_random();
    int start = accepts;
    for (int i = 0; i < 20000 && accepts - start < 1000; i++) begin
      heard__ENA    = ($urandom_range(0, 9) < 4);
      heard2__ENA   = ($urandom_range(0, 9) < 4);
      heard_meth    = $urandom; heard_v = $urandom;
      heard2_a      = 16'($urandom); heard2_b = 16'($urandom);
      pipe_enq__RDY = ($urandom_range(0, 9) < 7);
      cyc(1);
    end
    heard__ENA = 1'b0; heard2__ENA = 1'b0; pipe_enq__RDY = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1);
    checks++;
    if (accepts - start < 1000 || exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain got accepts %0d left %0d want >=1000 0", accepts - start, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_heard();
    test_heard2_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
